// File: rtl/core_pkg.sv
// Shared control-path definitions for the multi-cycle core:
// opcode constants, ALU op codes and the sequencer state set.
package core_pkg;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef enum logic [2:0] {
    S_BOOT,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

endpackage

// File: rtl/handshake_wait_timer.sv
// Counts consecutive req-high/ready-low cycles of a handshake.
// Ports: clk, rst_n, clear_i, count_en_i -> expired_o.
module handshake_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic count_en_i,
  output logic expired_o
);

  localparam int W = $clog2(MAX_WAIT + 1);

  logic [W-1:0] cnt_q;

  // High on the wait cycle that brings the count to MAX_WAIT.
  assign expired_o = count_en_i &&
                     (cnt_q == W'(MAX_WAIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (count_en_i) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/multicycle_core_sequencer.sv
// Multi-cycle control FSM: FETCH/DECODE/EXECUTE/MEM/WB, owns pc/ir.
// Ports: imem/dmem req-ready, alu_zero, imm in; pc, ir, ctrl, status out.
module multicycle_core_sequencer
  import core_pkg::*;
#(
  parameter int          XLEN     = 64,
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          MAX_WAIT = 15,
  parameter int          CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  input  logic              imem_ready,
  input  logic [31:0]       instr_in,
  output logic              dmem_req,
  output logic              dmem_we,
  input  logic              dmem_ready,
  input  logic              alu_zero,
  input  logic [XLEN-1:0]   imm,
  output logic [ADDR_W-1:0] pc,
  output logic [31:0]       ir,
  output logic              alu_src,
  output logic [1:0]        alu_op,
  output logic              mem_to_reg,
  output logic              reg_write_en,
  output logic [CNT_W-1:0]  instret,
  output logic              halt,
  output logic              timeout_err
);

  state_t             state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [31:0]        ir_q;
  logic [CNT_W-1:0]   instret_q;
  logic               halt_q;
  logic               tmo_q;

  logic [6:0] opc;
  logic       is_r, is_ld, is_sd, is_beq;
  logic       in_fetch, in_exec, in_mem, in_wb;

  assign opc    = ir_q[6:0];
  assign is_r   = (opc == OP_R);
  assign is_ld  = (opc == OP_LD);
  assign is_sd  = (opc == OP_SD);
  assign is_beq = (opc == OP_BEQ);

  assign in_fetch = (state_q == S_FETCH);
  assign in_exec  = (state_q == S_EXECUTE);
  assign in_mem   = (state_q == S_MEM);
  assign in_wb    = (state_q == S_WB);

  assign imem_req     = in_fetch;
  assign dmem_req     = in_mem;
  assign dmem_we      = in_mem & is_sd;
  assign alu_src      = in_exec & (is_ld | is_sd);
  assign mem_to_reg   = in_wb & is_ld;
  assign reg_write_en = in_wb;

  always_comb begin
    alu_op = ALU_ADD;
    if (in_exec) begin
      unique case (1'b1)
        is_beq:  alu_op = ALU_SUB;
        is_r:    alu_op = ALU_FUNCT;
        default: alu_op = ALU_ADD;
      endcase
    end
  end

  assign pc          = pc_q;
  assign ir          = ir_q;
  assign instret     = instret_q;
  assign halt        = halt_q;
  assign timeout_err = tmo_q;

  // Branch offset is imm<<1; only the bits that land in pc matter.
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] pc_br;
  logic [ADDR_W-1:0] pc_next;
  logic              unused_imm;

  assign pc_plus4   = pc_q + ADDR_W'(4);
  assign pc_br      = pc_q + {imm[ADDR_W-2:0], 1'b0};
  assign pc_next    = (is_beq && alu_zero) ? pc_br : pc_plus4;
  assign unused_imm = ^imm[XLEN-1:ADDR_W-1];

  // One timer shared by the fetch and data handshakes.
  logic wt_clear;
  logic wt_cnt;
  logic wt_exp;

  assign wt_cnt   = (in_fetch & ~imem_ready) |
                    (in_mem & ~dmem_ready);
  assign wt_clear = ~wt_cnt;

  handshake_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (wt_clear),
    .count_en_i (wt_cnt),
    .expired_o  (wt_exp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_BOOT;
      pc_q      <= ADDR_W'(RESET_PC);
      ir_q      <= '0;
      instret_q <= '0;
      halt_q    <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      unique case (state_q)
        S_BOOT: state_q <= S_FETCH;
        S_FETCH: begin
          if (imem_ready) begin
            ir_q    <= instr_in;
            state_q <= S_DECODE;
          end else if (wt_exp) begin
            tmo_q   <= 1'b1;
            halt_q  <= 1'b1;
            state_q <= S_HALT;
          end
        end
        S_DECODE: begin
          if (is_r | is_ld | is_sd | is_beq) begin
            state_q <= S_EXECUTE;
          end else begin
            halt_q  <= 1'b1;
            state_q <= S_HALT;
          end
        end
        S_EXECUTE: begin
          if (is_beq) begin
            pc_q      <= pc_next;
            instret_q <= instret_q + CNT_W'(1);
            state_q   <= S_FETCH;
          end else if (is_r) begin
            state_q <= S_WB;
          end else begin
            state_q <= S_MEM;
          end
        end
        S_MEM: begin
          if (dmem_ready) begin
            if (is_sd) begin
              pc_q      <= pc_plus4;
              instret_q <= instret_q + CNT_W'(1);
              state_q   <= S_FETCH;
            end else begin
              state_q <= S_WB;
            end
          end else if (wt_exp) begin
            tmo_q   <= 1'b1;
            halt_q  <= 1'b1;
            state_q <= S_HALT;
          end
        end
        S_WB: begin
          pc_q      <= pc_plus4;
          instret_q <= instret_q + CNT_W'(1);
          state_q   <= S_FETCH;
        end
        S_HALT: state_q <= S_HALT;
        default: begin
          halt_q  <= 1'b1;
          state_q <= S_HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_core_sequencer.sv
// Bench for multicycle_core_sequencer: queue-based instruction
// model checked every cycle, directed cases plus random programs.
module tb_multicycle_core_sequencer;

  localparam logic [6:0] T_R   = 7'b0110011;
  localparam logic [6:0] T_LD  = 7'b0000011;
  localparam logic [6:0] T_SD  = 7'b0100011;
  localparam logic [6:0] T_BEQ = 7'b1100011;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        imem_req, imem_ready = 0;
  logic [31:0] instr_in = 0;
  logic        dmem_req, dmem_we, dmem_ready = 0;
  logic        alu_zero = 0;
  logic [63:0] imm = 0;
  logic [31:0] pc, ir, instret;
  logic        alu_src, mem_to_reg, reg_write_en;
  logic [1:0]  alu_op;
  logic        halt, timeout_err;

  multicycle_core_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_ready(imem_ready),
    .instr_in(instr_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_ready(dmem_ready), .alu_zero(alu_zero),
    .imm(imm), .pc(pc), .ir(ir),
    .alu_src(alu_src), .alu_op(alu_op),
    .mem_to_reg(mem_to_reg),
    .reg_write_en(reg_write_en),
    .instret(instret), .halt(halt),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Model: the current instruction is a queue of remaining steps.
  typedef enum {K_BOOT, K_FETCH, K_DEC, K_EXE,
                K_MEM, K_WB, K_HALT} kind_t;
  typedef kind_t kq_t[$];

  kq_t         sched;
  logic [31:0] m_pc, m_ir, m_ic;
  logic        m_to;
  int          mw;

  function automatic kq_t path(input logic [6:0] o);
    kq_t q;
    q.push_back(K_DEC);
    case (o)
      T_R:   begin q.push_back(K_EXE); q.push_back(K_WB); end
      T_LD:  begin q.push_back(K_EXE); q.push_back(K_MEM);
                   q.push_back(K_WB); end
      T_SD:  begin q.push_back(K_EXE); q.push_back(K_MEM); end
      T_BEQ: q.push_back(K_EXE);
      default: q.push_back(K_HALT);
    endcase
    return q;
  endfunction

  task automatic m_retire(input logic take);
    logic [63:0] off;
    off = imm << 1;
    m_ic = m_ic + 1;
    m_pc = take ? m_pc + off[31:0] : m_pc + 32'd4;
  endtask

  task automatic m_wait();
    mw++;
    if (mw == 15) begin
      m_to = 1;
      sched.delete();
      sched.push_back(K_HALT);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sched.delete();
      sched.push_back(K_BOOT);
      m_pc = 0; m_ir = 0; m_ic = 0; m_to = 0; mw = 0;
    end else begin
      case (sched[0])
        K_BOOT: void'(sched.pop_front());
        K_FETCH:
          if (imem_ready) begin
            m_ir = instr_in; mw = 0;
            sched = path(instr_in[6:0]);
          end else m_wait();
        K_DEC: void'(sched.pop_front());
        K_EXE: begin
          if (m_ir[6:0] == T_BEQ) m_retire(alu_zero);
          void'(sched.pop_front());
        end
        K_MEM:
          if (dmem_ready) begin
            mw = 0;
            if (m_ir[6:0] == T_SD) m_retire(1'b0);
            void'(sched.pop_front());
          end else m_wait();
        K_WB: begin
          m_retire(1'b0);
          void'(sched.pop_front());
        end
        default: ;
      endcase
      if (sched.size() == 0) sched.push_back(K_FETCH);
    end
  end

  kind_t      h;
  logic [6:0] eo;
  logic [1:0] e_op;

  always @(negedge clk) begin
    if (rst_n) begin
      h  = sched[0];
      eo = m_ir[6:0];
      e_op = 2'b00;
      if (h == K_EXE && eo == T_BEQ) e_op = 2'b01;
      if (h == K_EXE && eo == T_R)   e_op = 2'b10;
      chk("imem_req", imem_req, h == K_FETCH);
      chk("dmem_req", dmem_req, h == K_MEM);
      chk("dmem_we", dmem_we, h == K_MEM && eo == T_SD);
      chk("alu_src", alu_src,
          h == K_EXE && (eo == T_LD || eo == T_SD));
      chk("alu_op", alu_op, e_op);
      chk("mem_to_reg", mem_to_reg, h == K_WB && eo == T_LD);
      chk("reg_write_en", reg_write_en, h == K_WB);
      chk("pc", pc, m_pc);
      chk("ir", ir, m_ir);
      chk("instret", instret, m_ic);
      chk("halt", halt, h == K_HALT);
      chk("timeout_err", timeout_err, m_to);
    end
  end

  task automatic do_reset();
    rst_n = 0; imem_ready = 0; dmem_ready = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic run_instr(input logic [31:0] ins,
                           input logic [63:0] im,
                           input logic z,
                           input int iw, input int dw,
                           output int dcyc, output int rwe_cyc,
                           output bit we_seen, output bit m2r);
    int n, cyc;
    dcyc = 0; rwe_cyc = 0; we_seen = 0; m2r = 0;
    imm = im; alu_zero = z; instr_in = ins;
    imem_ready = 0; dmem_ready = 0;
    n = 0;
    while (!imem_req && n < 50) begin
      @(negedge clk); n++;
    end
    if (!imem_req) begin
      chk("fetch_bound", 0, 1);
      return;
    end
    repeat (iw) @(negedge clk);
    imem_ready = 1;
    @(negedge clk);
    imem_ready = 0;
    cyc = iw + 2;
    for (n = 0; n < 40; n++) begin
      if (imem_req || halt) break;
      dmem_ready = 0;
      if (dmem_req) begin
        dcyc++;
        we_seen |= dmem_we;
        dmem_ready = (dcyc == dw + 1);
      end
      if (reg_write_en) rwe_cyc = cyc;
      if (mem_to_reg) m2r = 1;
      @(negedge clk);
      cyc++;
    end
    dmem_ready = 0;
    if (!(imem_req || halt)) chk("retire_bound", 0, 1);
  endtask

  int          dc, rc, n;
  bit          ws, ms;
  logic [31:0] p0, rv;
  logic [6:0]  opc;
  int          sel;

  localparam logic [31:0] I_R   = 32'h002081B3;
  localparam logic [31:0] I_LD  = 32'h0000B103;
  localparam logic [31:0] I_SD  = 32'h0020B023;
  localparam logic [31:0] I_BEQ = 32'h00208463;

  task automatic goto16();
    do_reset();
    repeat (4) run_instr(I_R, 0, 0, 0, 0, dc, rc, ws, ms);
  endtask

  initial begin
    do_reset();
    chk("rst_pc", pc, 0);
    chk("rst_instret", instret, 0);
    // 1: zero-wait R-type
    run_instr(I_R, 0, 0, 0, 0, dc, rc, ws, ms);
    chk("t1_rwe_cycle", rc, 4);
    chk("t1_pc", pc, 32'h4);
    chk("t1_model_pc", m_pc, 32'h4);
    chk("t1_instret", instret, 1);
    // 2: beq taken / not taken from pc=0x10
    goto16();
    chk("t2_pc_start", pc, 32'h10);
    run_instr(I_BEQ, 64'd8, 1, 0, 0, dc, rc, ws, ms);
    chk("t2_taken_pc", pc, 32'h20);
    chk("t2_taken_model", m_pc, 32'h20);
    chk("t2_taken_rwe", rc, 0);
    goto16();
    run_instr(I_BEQ, 64'd8, 0, 0, 0, dc, rc, ws, ms);
    chk("t2_nt_pc", pc, 32'h14);
    chk("t2_nt_rwe", rc, 0);
    // 3: ld with 3 wait states, then sd
    run_instr(I_LD, 0, 0, 0, 3, dc, rc, ws, ms);
    chk("t3_ld_dreq", dc, 4);
    chk("t3_ld_we", ws, 0);
    chk("t3_ld_m2r", ms, 1);
    chk("t3_ld_rwe", rc, 8);
    run_instr(I_SD, 0, 0, 0, 0, dc, rc, ws, ms);
    chk("t3_sd_we", ws, 1);
    chk("t3_sd_rwe", rc, 0);
    chk("t3_pc", pc, 32'h1C);
    chk("t3_instret", instret, 7);
    // 4: fetch timeout
    p0 = pc;
    n = 0;
    while (!imem_req && n < 50) begin @(negedge clk); n++; end
    imem_ready = 0;
    n = 0;
    while (imem_req && n < 40) begin @(negedge clk); n++; end
    chk("t4_waits", n, 15);
    chk("t4_halt", halt, 1);
    chk("t4_tmo", timeout_err, 1);
    chk("t4_pc", pc, p0);
    repeat (3) @(negedge clk);
    chk("t4_req_after", imem_req, 0);
    // 5: illegal opcode halts
    do_reset();
    run_instr(I_R, 0, 0, 0, 0, dc, rc, ws, ms);
    run_instr(32'h0000007F, 0, 0, 1, 0, dc, rc, ws, ms);
    chk("t5_halt", halt, 1);
    chk("t5_tmo", timeout_err, 0);
    chk("t5_instret", instret, 1);
    for (int i = 0; i < 3; i++) begin
      imem_ready = 1; instr_in = I_R;
      @(negedge clk);
      chk("t5_req", imem_req, 0);
    end
    imem_ready = 0;
    chk("t5_ir", ir, 32'h7F);
    chk("t5_pc", pc, 32'h4);
    // 6: reset during MEM of sd
    do_reset();
    run_instr(I_R, 0, 0, 0, 0, dc, rc, ws, ms);
    instr_in = I_SD; imem_ready = 1;
    @(negedge clk);
    imem_ready = 0; dmem_ready = 0;
    n = 0;
    while (!dmem_req && n < 10) begin @(negedge clk); n++; end
    chk("t6_in_mem", dmem_req, 1);
    #2 rst_n = 0;
    #1;
    chk("t6_dreq", dmem_req, 0);
    chk("t6_pc", pc, 0);
    chk("t6_instret", instret, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    #1 chk("t6_boot", imem_req, 0);
    @(negedge clk);
    chk("t6_fetch", imem_req, 1);
    // random programs
    do_reset();
    for (int k = 0; k < 300; k++) begin
      rv = $urandom;
      sel = $urandom_range(0, 3);
      opc = (sel == 0) ? T_R : (sel == 1) ? T_LD :
            (sel == 2) ? T_SD : T_BEQ;
      run_instr({rv[31:7], opc},
                64'($signed($urandom_range(0, 64)) - 32),
                1'($urandom_range(0, 1)),
                $urandom_range(0, 4), $urandom_range(0, 4),
                dc, rc, ws, ms);
      if (halt) break;
    end
    chk("rand_no_halt", halt, 0);
    chk("rand_instret", instret, m_ic);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want done");
    $fatal(1);
  end

endmodule
